// File: rtl/rr_arbiter4.sv
// Four-requester arbiter with registered one-hot grant, round-robin fairness,
// grant lock while the owner holds req, and a hold timeout that forces preemption.
// Optional macro ARB_FIXED_PRIO_EN switches the search to fixed priority (req[3] highest).
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       v,
  output logic       preempt
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_ZERO = CNT_W'(0);

  state_t           state_r, state_s;
  logic [1:0]       ptr_r, ptr_s;
  logic [1:0]       owner_r, owner_s;
  logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s;
  logic [3:0]       gnt_r, gnt_s;
  logic             v_r, v_s;
  logic             preempt_r, preempt_s;

  // {found, index} results of the three winner searches
  logic [2:0]       idle_pick_s, other_pick_s, timeout_pick_s;
  logic [3:0]       owner_mask_s;
  logic [1:0]       rel_ptr_s;

  assign owner_mask_s = 4'b0001 << owner_r;

`ifdef ARB_FIXED_PRIO_EN
  function automatic logic [2:0] prio_pick(input logic [3:0] r);
    logic [2:0] res;
    res = 3'b000;
    for (int k = 0; k < 4; k++) begin
      if (r[k]) res = {1'b1, 2'(k)};
    end
    return res;
  endfunction

  // Timeout search includes the owner, so it may win again.
  assign idle_pick_s    = prio_pick(req);
  assign other_pick_s   = prio_pick(req & ~owner_mask_s);
  assign timeout_pick_s = prio_pick(req);
  assign rel_ptr_s      = 2'b00;
`else
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    // Descending scan so the index closest to start is written last and wins.
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign idle_pick_s    = rr_pick(req, ptr_r);
  assign other_pick_s   = rr_pick(req & ~owner_mask_s, owner_r + 2'b01);
  assign timeout_pick_s = other_pick_s;
  assign rel_ptr_s      = owner_r + 2'b01;
`endif

  // Next-state, pointer, hold counter and registered-output values
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    owner_s    = owner_r;
    hold_cnt_s = hold_cnt_r;
    preempt_s  = 1'b0;
    gnt_s      = 4'b0000;
    v_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (idle_pick_s[2]) begin
          state_s    = GRANT;
          owner_s    = idle_pick_s[1:0];
          hold_cnt_s = HOLD_ZERO;
        end else begin
          owner_s    = 2'b00;
        end
      end
      GRANT: begin
        if (req[owner_r]) begin
          if (hold_cnt_r < HOLD_LAST) begin
            hold_cnt_s = hold_cnt_r + HOLD_ONE;
          end else if (other_pick_s[2]) begin
            owner_s    = timeout_pick_s[1:0];
            preempt_s  = (timeout_pick_s[1:0] != owner_r);
            ptr_s      = rel_ptr_s;
            hold_cnt_s = HOLD_ZERO;
          end else begin
            hold_cnt_s = HOLD_ZERO;
          end
        end else begin
          ptr_s      = rel_ptr_s;
          hold_cnt_s = HOLD_ZERO;
          if (other_pick_s[2]) begin
            owner_s = other_pick_s[1:0];
          end else begin
            state_s = IDLE;
            owner_s = 2'b00;
          end
        end
      end
      default: begin
        state_s    = IDLE;
        owner_s    = 2'b00;
        hold_cnt_s = HOLD_ZERO;
      end
    endcase
    if (state_s == GRANT) begin
      gnt_s = 4'b0001 << owner_s;
      v_s   = 1'b1;
    end else begin
      gnt_s = 4'b0000;
      v_s   = 1'b0;
    end
  end

  // State and output registers; async reset drops the grant immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      ptr_r      <= 2'b00;
      owner_r    <= 2'b00;
      hold_cnt_r <= HOLD_ZERO;
      gnt_r      <= 4'b0000;
      v_r        <= 1'b0;
      preempt_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      owner_r    <= owner_s;
      hold_cnt_r <= hold_cnt_s;
      gnt_r      <= gnt_s;
      v_r        <= v_s;
      preempt_r  <= preempt_s;
    end
  end

  assign gnt     = gnt_r;
  assign gnt_id  = owner_r;
  assign v       = v_r;
  assign preempt = preempt_r;

endmodule
